// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/interrupt controller
package hazard_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLAGS,
    INT_VECTOR
  } int_state_t;

  typedef logic [1:0] push_sel_t;

  localparam push_sel_t PUSH_SEL_PC_HI = 2'd0;
  localparam push_sel_t PUSH_SEL_PC_LO = 2'd1;
  localparam push_sel_t PUSH_SEL_FLAGS = 2'd2;

endpackage

// File: rtl/hazard_int_controller_if.sv
// rtl/hazard_int_controller_if.sv - pipeline-side signal bundle for the hazard/interrupt controller
interface hazard_int_controller_if;
  import hazard_pkg::*;

  logic [2:0] id_rsrc;
  logic [2:0] id_rdest;
  logic       id_uses_rsrc;
  logic       id_uses_rdest;
  logic       ex_mem_read;
  logic [2:0] ex_rdest;
  logic       ex_branch_taken;
  logic       mem_pc_choose_memory;
  logic       int_req;
  logic       push_ready;

  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       int_push_valid;
  push_sel_t  int_push_sel;
  logic       int_vector_load;
  logic       int_busy;

  // Controller side: observes the pipeline, drives stall/flush/push controls.
  modport master (
    input  id_rsrc, id_rdest, id_uses_rsrc, id_uses_rdest,
    input  ex_mem_read, ex_rdest, ex_branch_taken, mem_pc_choose_memory,
    input  int_req, push_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
    output int_push_valid, int_push_sel, int_vector_load, int_busy
  );

  // Pipeline side: supplies stage information, consumes the controls.
  modport slave (
    output id_rsrc, id_rdest, id_uses_rsrc, id_uses_rdest,
    output ex_mem_read, ex_rdest, ex_branch_taken, mem_pc_choose_memory,
    output int_req, push_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
    input  int_push_valid, int_push_sel, int_vector_load, int_busy
  );

endinterface

// File: rtl/hazard_int_controller_load_use_detector.sv
// rtl/hazard_int_controller_load_use_detector.sv - load-use register compare between EX and ID
module load_use_detector (
  input  logic [2:0] id_rsrc,
  input  logic [2:0] id_rdest,
  input  logic       id_uses_rsrc,
  input  logic       id_uses_rdest,
  input  logic       ex_mem_read,
  input  logic [2:0] ex_rdest,
  output logic       load_use_stall
);

  // A load in EX whose result is read by the ID instruction cannot be forwarded in time.
  always_comb begin
    load_use_stall = ex_mem_read &&
                     ((id_uses_rsrc  && (id_rsrc  == ex_rdest)) ||
                      (id_uses_rdest && (id_rdest == ex_rdest)));
  end

endmodule

// File: rtl/hazard_int_controller.sv
// rtl/hazard_int_controller.sv - stall/flush generation and interrupt entry sequencer
module hazard_int_controller
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input logic                     clk,
  input logic                     reset,
  hazard_int_controller_if.master bus
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  int_state_t state, state_next;
  logic [1:0] drain_cnt, drain_cnt_next;
  logic       int_pending, int_pending_next;
  logic       load_use_raw;
  logic       redirect;
  logic       hazard;
  logic       in_idle;
  logic       holding;

  logic       push_valid_q;
  push_sel_t  push_sel_q;
  logic       vector_load_q;
  logic       busy_q;

  load_use_detector u_load_use (
    .id_rsrc        (bus.id_rsrc),
    .id_rdest       (bus.id_rdest),
    .id_uses_rsrc   (bus.id_uses_rsrc),
    .id_uses_rdest  (bus.id_uses_rdest),
    .ex_mem_read    (bus.ex_mem_read),
    .ex_rdest       (bus.ex_rdest),
    .load_use_stall (load_use_raw)
  );

  assign redirect = bus.mem_pc_choose_memory | bus.ex_branch_taken;
  assign hazard   = redirect | load_use_raw;
  assign in_idle  = (state == IDLE);
  assign holding  = (state == DRAIN) || (state == PUSH_HI) ||
                    (state == PUSH_LO) || (state == PUSH_FLAGS);

  // Next-state: a request seen this cycle counts immediately so entry starts one edge later.
  always_comb begin
    state_next       = state;
    drain_cnt_next   = drain_cnt;
    int_pending_next = int_pending | bus.int_req;
    case (state)
      IDLE: begin
        if ((int_pending | bus.int_req) && !hazard) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) state_next = PUSH_HI;
        else drain_cnt_next = drain_cnt - 2'd1;
      end
      PUSH_HI: begin
        if (bus.push_ready) state_next = PUSH_LO;
      end
      PUSH_LO: begin
        if (bus.push_ready) state_next = PUSH_FLAGS;
      end
      PUSH_FLAGS: begin
        if (bus.push_ready) begin
          state_next       = INT_VECTOR;
          int_pending_next = 1'b0;
        end
      end
      INT_VECTOR: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // State register with interrupt outputs registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      drain_cnt     <= 2'd0;
      int_pending   <= 1'b0;
      push_valid_q  <= 1'b0;
      push_sel_q    <= PUSH_SEL_PC_HI;
      vector_load_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_next;
      drain_cnt     <= drain_cnt_next;
      int_pending   <= int_pending_next;
      push_valid_q  <= (state_next == PUSH_HI) || (state_next == PUSH_LO) ||
                       (state_next == PUSH_FLAGS);
      push_sel_q    <= (state_next == PUSH_LO)    ? PUSH_SEL_PC_LO :
                       (state_next == PUSH_FLAGS) ? PUSH_SEL_FLAGS : PUSH_SEL_PC_HI;
      vector_load_q <= (state_next == INT_VECTOR);
      busy_q        <= (state_next != IDLE);
    end
  end

  // Stall/flush priority; redirects keep the PC moving even while the sequencer holds fetch.
  always_comb begin
    logic lu;
    lu              = load_use_raw && in_idle && !redirect;
    bus.pc_write    = redirect ? 1'b1 : (holding ? 1'b0 : !lu);
    bus.if_id_write = !lu;
    bus.if_id_flush = redirect | holding;
    bus.id_ex_flush = redirect | lu;
    bus.ex_mem_flush = bus.mem_pc_choose_memory;
  end

  assign bus.int_push_valid  = push_valid_q;
  assign bus.int_push_sel    = push_sel_q;
  assign bus.int_vector_load = vector_load_q;
  assign bus.int_busy        = busy_q;

endmodule

// File: tb/tb_hazard_int_controller.sv
// tb/tb_hazard_int_controller.sv - randomized self-checking bench for hazard_int_controller
module tb_hazard_int_controller;

  localparam int D = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int   m_step;
  bit   m_pending;

  logic s_pcw, s_ifw, s_iff, s_idf, s_exf, s_pv, s_vec, s_busy;
  logic [1:0] s_sel;

  hazard_int_controller_if hif ();

  hazard_int_controller #(.DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit load_use();
    return hif.ex_mem_read &&
           ((hif.id_uses_rsrc  && hif.id_rsrc  == hif.ex_rdest) ||
            (hif.id_uses_rdest && hif.id_rdest == hif.ex_rdest));
  endfunction

  // Model: m_step 0 = idle, 1..D draining, D+1..D+3 the three pushes, D+4 vector load.
  task automatic compare_all();
    bit redir, lu, hold, pv;
    int sel;
    redir = hif.mem_pc_choose_memory || hif.ex_branch_taken;
    lu    = load_use() && m_step == 0 && !redir;
    hold  = m_step >= 1 && m_step <= D + 3;
    pv    = m_step >= D + 1 && m_step <= D + 3;
    sel   = pv ? m_step - (D + 1) : 0;
    s_pcw = hif.pc_write; s_ifw = hif.if_id_write; s_iff = hif.if_id_flush;
    s_idf = hif.id_ex_flush; s_exf = hif.ex_mem_flush; s_pv = hif.int_push_valid;
    s_sel = hif.int_push_sel; s_vec = hif.int_vector_load; s_busy = hif.int_busy;
    chk("pc_write", s_pcw, redir ? 1 : (hold ? 0 : int'(!lu)));
    chk("if_id_write", s_ifw, int'(!lu));
    chk("if_id_flush", s_iff, int'(redir || hold));
    chk("id_ex_flush", s_idf, int'(redir || lu));
    chk("ex_mem_flush", s_exf, int'(hif.mem_pc_choose_memory));
    chk("int_push_valid", s_pv, int'(pv));
    chk("int_push_sel", s_sel, sel);
    chk("int_vector_load", s_vec, int'(m_step == D + 4));
    chk("int_busy", s_busy, int'(m_step != 0));
  endtask

  task automatic model_edge();
    bit hz, pend;
    if (!reset) begin
      m_step = 0;
      m_pending = 0;
      return;
    end
    hz   = hif.mem_pc_choose_memory || hif.ex_branch_taken || load_use();
    pend = m_pending || hif.int_req;
    if (m_step == 0) begin
      if (pend && !hz) m_step = 1;
    end else if (m_step <= D) begin
      m_step++;
    end else if (m_step <= D + 3) begin
      if (hif.push_ready) begin
        m_step++;
        if (m_step == D + 4) pend = 0;
      end
    end else begin
      m_step = 0;
    end
    m_pending = pend;
  endtask

  task automatic cycle();
    #2;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic quiet();
    hif.id_rsrc = 3'd0; hif.id_rdest = 3'd0;
    hif.id_uses_rsrc = 1'b0; hif.id_uses_rdest = 1'b0;
    hif.ex_mem_read = 1'b0; hif.ex_rdest = 3'd0;
    hif.ex_branch_taken = 1'b0; hif.mem_pc_choose_memory = 1'b0;
    hif.int_req = 1'b0; hif.push_ready = 1'b1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  task automatic set_load_use();
    hif.ex_mem_read = 1'b1; hif.ex_rdest = 3'd3;
    hif.id_rsrc = 3'd3; hif.id_uses_rsrc = 1'b1;
  endtask

  initial begin
    int vec_at, vec_cnt, sel1_cnt;
    quiet();
    reset = 1'b0;
    m_step = 0;
    m_pending = 0;
    @(negedge clk);
    do_reset();

    // Reset/idle values.
    cycle();
    chk("idle_pc_write", s_pcw, 1);
    chk("idle_if_id_write", s_ifw, 1);
    chk("idle_busy", s_busy, 0);

    // Load-use stall and its removal.
    set_load_use();
    cycle();
    chk("lu_pc_write", s_pcw, 0);
    chk("lu_if_id_write", s_ifw, 0);
    chk("lu_id_ex_flush", s_idf, 1);
    hif.id_uses_rsrc = 1'b0;
    cycle();
    chk("lu_off_pc_write", s_pcw, 1);

    // Priority of branch and memory redirects over load-use.
    set_load_use();
    hif.ex_branch_taken = 1'b1;
    cycle();
    chk("br_if_id_flush", s_iff, 1);
    chk("br_pc_write", s_pcw, 1);
    hif.mem_pc_choose_memory = 1'b1;
    cycle();
    chk("mem_ex_mem_flush", s_exf, 1);
    quiet();

    // Minimum interrupt entry.
    do_reset();
    vec_at = -1;
    for (int k = 0; k <= 8; k++) begin
      hif.int_req = (k == 0);
      cycle();
      if (s_vec && vec_at < 0) vec_at = k;
      if (k == 2) chk("int_drain_flush", s_iff, 1);
      if (k == 5) chk("int_sel_lo", s_sel, 1);
      if (k == 8) chk("int_done_busy", s_busy, 0);
    end
    chk("int_vector_cycle", vec_at, 7);

    // Backpressure during PUSH_LO.
    do_reset();
    vec_at = -1; sel1_cnt = 0;
    for (int k = 0; k <= 11; k++) begin
      hif.int_req = (k == 0);
      hif.push_ready = !(k == 5 || k == 6);
      cycle();
      if (s_pv && s_sel == 2'd1) sel1_cnt++;
      if (s_vec && vec_at < 0) vec_at = k;
    end
    chk("bp_sel_lo_cycles", sel1_cnt, 3);
    chk("bp_vector_cycle", vec_at, 9);
    quiet();

    // Reset while pushing PC high half.
    do_reset();
    vec_at = -1;
    for (int k = 0; k <= 4; k++) begin
      hif.int_req = (k == 0);
      if (k == 4) reset = 1'b0;
      cycle();
    end
    chk("rst_was_push_hi", s_pv, 1);
    reset = 1'b1;
    cycle();
    chk("rst_busy", s_busy, 0);
    chk("rst_push_valid", s_pv, 0);
    chk("rst_pc_write", s_pcw, 1);
    vec_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_vec) vec_cnt++;
    end
    chk("rst_no_vector", vec_cnt, 0);

    // Deferred entry behind a load-use stall, plus a duplicate request in DRAIN.
    do_reset();
    vec_at = -1; vec_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      quiet();
      if (k <= 2) set_load_use();
      hif.int_req = (k == 0 || k == 5);
      cycle();
      if (s_vec) begin
        vec_cnt++;
        if (vec_at < 0) vec_at = k;
      end
    end
    chk("defer_vector_cycle", vec_at, 10);
    chk("defer_vector_count", vec_cnt, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      hif.id_rsrc = 3'($urandom_range(0, 7));
      hif.id_rdest = 3'($urandom_range(0, 7));
      hif.ex_rdest = 3'($urandom_range(0, 7));
      hif.id_uses_rsrc = 1'($urandom_range(0, 1));
      hif.id_uses_rdest = 1'($urandom_range(0, 1));
      hif.ex_mem_read = ($urandom_range(0, 2) == 0);
      hif.ex_branch_taken = ($urandom_range(0, 7) == 0);
      hif.mem_pc_choose_memory = ($urandom_range(0, 9) == 0);
      hif.int_req = ($urandom_range(0, 15) == 0);
      hif.push_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
